// File: rtl/tmds_encoder_pipe.sv
// rtl/tmds_encoder_pipe.sv - two-stage multi-channel TMDS/TERC4 symbol encoder
// Stage 1 transition-minimises video bytes; stage 2 applies DC balance or a fixed code table.
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  input  logic [1:0]            mode_in,
  input  logic [8*NUM_CH-1:0]   data_in,
  input  logic [2*NUM_CH-1:0]   ctrl_in,
  input  logic [4*NUM_CH-1:0]   terc_in,
  output logic [10*NUM_CH-1:0]  tmds_out,
  output logic                  valid_out,
  output logic [5*NUM_CH-1:0]   disp_out
);

  localparam logic [1:0] MODE_VIDEO = 2'd0;
  localparam logic [1:0] MODE_CTRL  = 2'd1;
  localparam logic [1:0] MODE_TERC  = 2'd2;

  function automatic logic [8:0] tm_word(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones = 4'd0;
    for (int k = 0; k < 8; k++) ones = ones + {3'b000, d[k]};
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q = 9'd0;
    q[0] = d[0];
    for (int k = 1; k < 8; k++) q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] terc_sym(input logic [3:0] n);
    logic [9:0] s;
    case (n)
      4'h0: s = 10'h29C;  4'h1: s = 10'h263;  4'h2: s = 10'h2E4;  4'h3: s = 10'h2E2;
      4'h4: s = 10'h171;  4'h5: s = 10'h11E;  4'h6: s = 10'h18E;  4'h7: s = 10'h13C;
      4'h8: s = 10'h2CC;  4'h9: s = 10'h139;  4'hA: s = 10'h19C;  4'hB: s = 10'h2C6;
      4'hC: s = 10'h28E;  4'hD: s = 10'h271;  4'hE: s = 10'h163;  default: s = 10'h2C3;
    endcase
    return s;
  endfunction

  logic       s1_valid;
  logic [1:0] s1_mode;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 2'd0;
      valid_out <= 1'b0;
    end else begin
      s1_valid  <= valid_in;
      s1_mode   <= mode_in;
      valid_out <= s1_valid;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [9:0] GUARD_SYM = (i % 2 == 0) ? 10'h2CC : 10'h133;

    logic [8:0] s1_qm;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_terc;
    logic [9:0] sym;
    logic [4:0] cnt;
    logic [9:0] nxt_sym;
    logic [4:0] nxt_cnt;
    logic [3:0] n1;
    logic [4:0] bal;
    logic       cnt_pos;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        s1_qm   <= 9'd0;
        s1_ctrl <= 2'd0;
        s1_terc <= 4'd0;
      end else begin
        s1_qm   <= tm_word(data_in[8*i +: 8]);
        s1_ctrl <= ctrl_in[2*i +: 2];
        s1_terc <= terc_in[4*i +: 4];
      end
    end

    // cnt is 5-bit two's complement; bal = n1 - n0 = 2*n1 - 8, wrapping arithmetic.
    always_comb begin
      nxt_sym = 10'd0;
      nxt_cnt = 5'd0;
      n1 = 4'd0;
      for (int k = 0; k < 8; k++) n1 = n1 + {3'b000, s1_qm[k]};
      bal = {n1, 1'b0} - 5'd8;
      cnt_pos = !cnt[4] && (cnt != 5'd0);
      case (s1_mode)
        MODE_VIDEO: begin
          if ((cnt == 5'd0) || (n1 == 4'd4)) begin
            nxt_sym = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
            nxt_cnt = s1_qm[8] ? (cnt + bal) : (cnt - bal);
          end else if ((cnt_pos && (n1 > 4'd4)) || (cnt[4] && (n1 < 4'd4))) begin
            nxt_sym = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            nxt_cnt = cnt + {3'b000, s1_qm[8], 1'b0} - bal;
          end else begin
            nxt_sym = {1'b0, s1_qm[8], s1_qm[7:0]};
            nxt_cnt = cnt + bal - {3'b000, ~s1_qm[8], 1'b0};
          end
        end
        MODE_CTRL: begin
          case (s1_ctrl)
            2'b00:   nxt_sym = 10'h354;
            2'b01:   nxt_sym = 10'h0AB;
            2'b10:   nxt_sym = 10'h154;
            default: nxt_sym = 10'h2AB;
          endcase
        end
        MODE_TERC: nxt_sym = terc_sym(s1_terc);
        default:   nxt_sym = GUARD_SYM;
      endcase
    end

    // Bubbles freeze the symbol and the running disparity.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        sym <= 10'd0;
        cnt <= 5'd0;
      end else if (s1_valid) begin
        sym <= nxt_sym;
        cnt <= nxt_cnt;
      end
    end

    assign tmds_out[10*i +: 10] = sym;
    assign disp_out[5*i +: 5]   = cnt;
  end

endmodule
